if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 132 +++++++++++++
 tb/tb_if_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- byte-serial instruction fetch stage.
//
// Fetches each 32-bit instruction as four single-byte reads from a
// byte-wide memory port. At most one request is ever outstanding. The
// assembled word is presented to decode until decode accepts it. A redirect
// from execute (jump_i) overrides everything else.
//
// Ports
//   clk           : single clock, all state on the rising edge
//   rst           : synchronous reset, active low
//   stall_i       : blocks issue of new memory requests only
//   jump_i        : one-cycle redirect strobe
//   jump_addr_i   : redirect target (low two bits ignored)
//   mem_req_o     : byte read request (combinational)
//   mem_addr_o    : byte address of the request, pc_o + byte index
//   mem_grant_i   : memory accepts the request this cycle
//   mem_rvalid_i  : read data valid for the outstanding request
//   mem_data_i    : read data byte
//   id_ready_i    : decode accepts the presented instruction
//   inst_valid_o  : pc_o / inst_o hold a complete instruction
//   pc_o          : PC of the instruction being fetched or presented
//   inst_o        : assembled instruction word, little-endian
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_grant_i,
  input  logic        mem_rvalid_i,
  input  logic [7:0]  mem_data_i,
  input  logic        id_ready_i,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // issue the next byte request
    S_WAIT  = 2'd1,  // one request outstanding
    S_HOLD  = 2'd2,  // complete instruction presented to decode
    S_FLUSH = 2'd3   // waiting out a byte made stale by a redirect
  } state_t;

  state_t      r_state;
  logic [1:0]  r_k;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_valid;

  logic [31:0] w_jump_pc;
  logic [31:0] w_reset_pc;
  logic        w_unused;

  // Instructions are word aligned; the low address bits are dropped.
  assign w_jump_pc  = {jump_addr_i[31:2], 2'b00};
  assign w_reset_pc = {RESET_PC[31:2], 2'b00};
  assign w_unused   = ^jump_addr_i[1:0];

  // Gated by rst so no request escapes during a reset cycle, and by jump_i
  // so a request is never issued for a PC that is being replaced.
  assign mem_req_o  = rst & (r_state == S_FETCH) & ~stall_i & ~jump_i;
  assign mem_addr_o = r_pc + {30'd0, r_k};

  assign inst_valid_o = r_valid;
  assign pc_o         = r_pc;
  assign inst_o       = r_inst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_k     <= 2'd0;
      r_pc    <= w_reset_pc;
      r_inst  <= 32'd0;
      r_valid <= 1'b0;
    end else if (jump_i) begin
      // A redirect wins over every other event, including a handoff in
      // HOLD (the presented instruction counts as consumed).
      r_pc    <= w_jump_pc;
      r_k     <= 2'd0;
      r_valid <= 1'b0;
      case (r_state)
        // A byte still in flight must be drained before a new request is
        // issued, otherwise it would be taken as data for the target.
        S_WAIT:  r_state <= mem_rvalid_i ? S_FETCH : S_FLUSH;
        S_FLUSH: r_state <= mem_rvalid_i ? S_FETCH : S_FLUSH;
        default: r_state <= S_FETCH;
      endcase
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_req_o && mem_grant_i) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            r_inst[{r_k, 3'b000} +: 8] <= mem_data_i;
            if (r_k == 2'd3) begin
              r_k     <= 2'd0;
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end else begin
              r_k     <= r_k + 2'd1;
              r_state <= S_FETCH;
            end
          end
        end
        S_HOLD: begin
          if (id_ready_i) begin
            r_valid <= 1'b0;
            r_pc    <= r_pc + 32'd4;
            r_state <= S_FETCH;
          end
        end
        S_FLUSH: begin
          if (mem_rvalid_i) begin
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A byte-addressed memory model answers requests with configurable grant
// probability and read latency. A reference process tracks which PC the
// next presented instruction must come from (reset, redirects, handoffs)
// and queues the expected {pc, word}; a monitor pops and compares whenever
// the DUT presents a new instruction. Directed sequences cover reset,
// timing, hold, stall, grant back-pressure, flush and PC wrap; a random
// phase follows.
// -----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_grant_i;
  logic        mem_rvalid_i;
  logic [7:0]  mem_data_i;
  logic        id_ready_i;
  logic        inst_valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_grant_i  (mem_grant_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_data_i   (mem_data_i),
    .id_ready_i   (id_ready_i),
    .inst_valid_o (inst_valid_o),
    .pc_o         (pc_o),
    .inst_o       (inst_o)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory contents: addresses 0..3 hold 32'h00100513, the rest a hash.
  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] h;
    logic [31:0] w0;
    w0 = 32'h0010_0513;
    if (a < 32'd4) return w0[{a[1:0], 3'b000} +: 8];
    h = a * 32'h9E37_79B1;
    return h[31:24];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {byte_at(pc + 32'd3), byte_at(pc + 32'd2), byte_at(pc + 32'd1), byte_at(pc)};
  endfunction

  // ---------------------------------------------------------------------------
  // Memory model and random stimulus driver.
  //   +1 after the edge: memory response for this cycle
  //   +2              : control inputs (random mode only)
  //   +3              : grant decision, after mem_req_o has settled
  // ---------------------------------------------------------------------------
  bit          rand_mode = 1'b0;
  int          grant_pct = 100;
  int          lat_min   = 0;
  int          lat_max   = 0;
  bit          have_out  = 1'b0;
  bit          acc_pend  = 1'b0;
  logic [31:0] out_addr;
  logic [31:0] acc_addr;
  int          lat;

  always begin
    @(posedge clk);
    #1;
    if (rst === 1'b0) begin
      have_out = 1'b0;
      acc_pend = 1'b0;
    end
    if (acc_pend) begin
      have_out = 1'b1;
      out_addr = acc_addr;
      lat      = int'($urandom_range(lat_max, lat_min));
      acc_pend = 1'b0;
    end
    if (have_out && lat == 0) begin
      mem_rvalid_i = 1'b1;
      mem_data_i   = byte_at(out_addr);
      have_out     = 1'b0;
    end else begin
      if (have_out) lat--;
      mem_rvalid_i = 1'b0;
      mem_data_i   = 8'($urandom);
    end
    #1;
    if (rand_mode) begin
      rst         = ($urandom_range(199) != 0);
      stall_i     = ($urandom_range(9) < 2);
      jump_i      = ($urandom_range(19) == 0);
      jump_addr_i = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
      id_ready_i  = ($urandom_range(1) == 1);
    end
    #1;
    mem_grant_i = mem_req_o && ($urandom_range(99) < grant_pct);
    if (mem_req_o === 1'b1) check("one_outstanding", {31'd0, have_out}, 32'd0);
    if (mem_grant_i) begin
      acc_pend = 1'b1;
      acc_addr = mem_addr_o;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: inputs and presentation state are sampled at the falling
  // edge; the effect on the expected-instruction queue is applied just after
  // the following rising edge, once the monitor has seen that cycle.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  logic        snap_rst, snap_jump, snap_valid, snap_ready;
  logic [31:0] snap_jaddr;
  logic [31:0] model_pc;

  always @(negedge clk) begin
    snap_rst   = rst;
    snap_jump  = jump_i;
    snap_jaddr = jump_addr_i;
    snap_valid = inst_valid_o;
    snap_ready = id_ready_i;
  end

  always begin
    @(posedge clk);
    #1;
    if (snap_rst === 1'b0) begin
      model_pc = RESET_PC;
      exp_q.delete();
      exp_q.push_back('{pc: model_pc, inst: word_at(model_pc)});
    end else if (snap_rst === 1'b1 && snap_jump === 1'b1) begin
      model_pc = {snap_jaddr[31:2], 2'b00};
      exp_q.delete();
      exp_q.push_back('{pc: model_pc, inst: word_at(model_pc)});
    end else if (snap_rst === 1'b1 && snap_valid === 1'b1 && snap_ready === 1'b1) begin
      model_pc = model_pc + 32'd4;
      exp_q.push_back('{pc: model_pc, inst: word_at(model_pc)});
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares each newly presented instruction with the queue head.
  // ---------------------------------------------------------------------------
  bit   seen = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if ($time > 20) begin
      if (rst === 1'b0 || stall_i === 1'b1 || jump_i === 1'b1)
        check("req_blocked", {31'd0, mem_req_o}, 32'd0);
      if (inst_valid_o === 1'b1) begin
        if (!seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL inst_unexpected: presented pc %h with no instruction expected", pc_o);
          end else begin
            mon_e = exp_q.pop_front();
            $display("inst pc=%h inst=%h exp_pc=%h exp_inst=%h", pc_o, inst_o, mon_e.pc, mon_e.inst);
            check("inst_pc", pc_o, mon_e.pc);
            check("inst_word", inst_o, mon_e.inst);
          end
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequences followed by the random phase.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit found;
    int waited;
    rst          = 1'b0;
    stall_i      = 1'b0;
    jump_i       = 1'b0;
    jump_addr_i  = 32'd0;
    id_ready_i   = 1'b0;
    mem_grant_i  = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_data_i   = 8'd0;

    // Reset state.
    repeat (3) begin
      step();
      @(negedge clk);
      check("rst_pc", pc_o, RESET_PC);
      check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
      check("rst_inst", inst_o, 32'd0);
      check("rst_req", {31'd0, mem_req_o}, 32'd0);
    end

    // First instruction: requests at 0..3 in odd cycles, presented after 8.
    step();
    rst = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n % 2 == 1 && n <= 7) begin
        check("first_req", {31'd0, mem_req_o}, 32'd1);
        check("first_addr", mem_addr_o, 32'((n - 1) / 2));
      end
      check("first_valid", {31'd0, inst_valid_o}, (n == 9) ? 32'd1 : 32'd0);
      if (n < 9) step();
    end
    check("first_inst", inst_o, 32'h0010_0513);
    check("first_pc", pc_o, 32'd0);

    // Decode not ready: everything held, no requests.
    repeat (5) begin
      step();
      @(negedge clk);
      check("hold_valid", {31'd0, inst_valid_o}, 32'd1);
      check("hold_pc", pc_o, 32'd0);
      check("hold_inst", inst_o, 32'h0010_0513);
      check("hold_req", {31'd0, mem_req_o}, 32'd0);
    end
    step();
    id_ready_i = 1'b1;
    @(negedge clk);
    check("handoff_valid", {31'd0, inst_valid_o}, 32'd1);

    // Stall in FETCH right after the handoff.
    step();
    id_ready_i = 1'b0;
    stall_i    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_req", {31'd0, mem_req_o}, 32'd0);
      check("stall_pc", pc_o, 32'd4);
      step();
    end

    // Grant withheld: request and address must stay put.
    stall_i   = 1'b0;
    grant_pct = 0;
    repeat (4) begin
      @(negedge clk);
      check("nogrant_req", {31'd0, mem_req_o}, 32'd1);
      check("nogrant_addr", mem_addr_o, 32'd4);
      step();
    end
    grant_pct = 100;
    lat_min   = 2;
    lat_max   = 2;

    // Redirect while a byte is outstanding: flush it, refetch at 0x1000.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (have_out && mem_rvalid_i !== 1'b1) found = 1'b1;
      else step();
    end
    check("flush_setup", {31'd0, found}, 32'd1);
    jump_i      = 1'b1;
    jump_addr_i = 32'h0000_1002;
    step();
    jump_i = 1'b0;
    @(negedge clk);
    check("jump_pc", pc_o, 32'h0000_1000);
    check("jump_valid", {31'd0, inst_valid_o}, 32'd0);
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_req_o === 1'b1) found = 1'b1;
      else begin
        waited++;
        @(negedge clk);
      end
    end
    check("flush_req_seen", {31'd0, found}, 32'd1);
    check("flush_waited", {31'd0, waited != 0}, 32'd1);
    check("flush_addr", mem_addr_o, 32'h0000_1000);

    // PC wrap at the top of the address space.
    step();
    lat_min     = 0;
    lat_max     = 0;
    jump_i      = 1'b1;
    jump_addr_i = 32'hFFFF_FFFC;
    step();
    jump_i = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (inst_valid_o === 1'b1) found = 1'b1;
    end
    check("wrap_present", {31'd0, found}, 32'd1);
    check("wrap_pc_top", pc_o, 32'hFFFF_FFFC);
    step();
    id_ready_i = 1'b1;
    step();
    id_ready_i = 1'b0;
    @(negedge clk);
    check("wrap_pc", pc_o, 32'd0);
    check("wrap_req", {31'd0, mem_req_o}, 32'd1);
    check("wrap_addr", mem_addr_o, 32'd0);

    // Random phase.
    step();
    grant_pct = 70;
    lat_min   = 0;
    lat_max   = 2;
    rand_mode = 1'b1;
    repeat (4000) step();
    rand_mode = 1'b0;
    step();
    rst        = 1'b1;
    stall_i    = 1'b0;
    jump_i     = 1'b0;
    id_ready_i = 1'b1;
    repeat (20) step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
